// File: rtl/mda_pwm_capture.sv
// PWM input capture: synchronizes and glitch-filters pwm_in, then measures rise-to-rise
// period and rise-to-fall high time in clk cycles, flagging a stalled input via timeout.
module mda_pwm_capture #(
  parameter int unsigned FILTER  = 2,
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pwm_in,
  output logic [15:0] period,
  output logic [15:0] duty_cycle,
  output logic        valid,
  output logic        timeout
);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_TMO} state_t;

  localparam logic [3:0] FCNT_MAX = 4'(FILTER - 1);

  logic        s1_q, s2_q;
  logic        filt_q, filt_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] hi_q, hi_d;
  logic [15:0] period_q, period_d;
  logic [15:0] duty_q, duty_d;
  logic        valid_q, valid_d;
  logic        tmo_q, tmo_d;
  state_t      state_q, state_d;
  logic        rise, fall, at_to, go_tmo;

  // Glitch filter: a level change must persist FILTER cycles at s2 to be accepted.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    rise   = 1'b0;
    fall   = 1'b0;
    if (s2_q == filt_q) begin
      fcnt_d = 4'd0;
    end else if (fcnt_q == FCNT_MAX) begin
      filt_d = s2_q;
      fcnt_d = 4'd0;
      rise   = s2_q;
      fall   = ~s2_q;
    end else begin
      fcnt_d = fcnt_q + 4'd1;
    end
  end

  always_comb begin
    if (rise)                 cnt_d = 16'd1;
    else if (cnt_q == 16'hFFFF) cnt_d = cnt_q;
    else                      cnt_d = cnt_q + 16'd1;
  end

  assign at_to = (cnt_q == TIMEOUT);

  // Edge events win over a coincident timeout in every state.
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    period_d = period_q;
    duty_d   = duty_q;
    valid_d  = 1'b0;
    tmo_d    = tmo_q;
    go_tmo   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise)                state_d = S_HIGH;
        else if (at_to && !fall) go_tmo  = 1'b1;
      end
      S_HIGH: begin
        if (fall) begin
          state_d = S_LOW;
          hi_d    = cnt_q;
        end else if (at_to) begin
          go_tmo = 1'b1;
        end
      end
      S_LOW: begin
        if (rise) begin
          state_d  = S_HIGH;
          period_d = cnt_q;
          duty_d   = hi_q;
          valid_d  = 1'b1;
        end else if (at_to) begin
          go_tmo = 1'b1;
        end
      end
      S_TMO: begin
        if (rise) begin
          state_d = S_HIGH;
          tmo_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (go_tmo) begin
      state_d  = S_TMO;
      tmo_d    = 1'b1;
      period_d = 16'hFFFF;
      duty_d   = filt_q ? 16'hFFFF : 16'h0000;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      filt_q   <= 1'b0;
      fcnt_q   <= 4'd0;
      cnt_q    <= 16'd0;
      hi_q     <= 16'd0;
      period_q <= 16'd0;
      duty_q   <= 16'd0;
      valid_q  <= 1'b0;
      tmo_q    <= 1'b0;
      state_q  <= S_IDLE;
    end else begin
      s1_q     <= pwm_in;
      s2_q     <= s1_q;
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      valid_q  <= valid_d;
      tmo_q    <= tmo_d;
      state_q  <= state_d;
    end
  end

  assign period     = period_q;
  assign duty_cycle = duty_q;
  assign valid      = valid_q;
  assign timeout    = tmo_q;

endmodule

// File: tb/tb_mda_pwm_capture.sv
// Bench for mda_pwm_capture: a cycle-accurate stimulus model predicts each report,
// which a monitor pops and compares whenever the DUT pulses valid.
module tb_mda_pwm_capture;

  localparam int TMO = 5000;

  logic        clk = 1'b0;
  logic        reset, pwm_in, pwm2;
  logic [15:0] period, duty_cycle, period2, duty2;
  logic        valid, timeout, valid2, timeout2;

  always #5 clk = ~clk;

  mda_pwm_capture #(.FILTER(2), .TIMEOUT(16'd5000)) u_dut (
    .clk(clk), .reset(reset), .pwm_in(pwm_in),
    .period(period), .duty_cycle(duty_cycle), .valid(valid), .timeout(timeout)
  );

  mda_pwm_capture #(.FILTER(3)) u_lat (
    .clk(clk), .reset(reset), .pwm_in(pwm2),
    .period(period2), .duty_cycle(duty2), .valid(valid2), .timeout(timeout2)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [15:0] per;
    logic [15:0] duty;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Stimulus model: 0 idle, 1 high, 2 low, 3 timed out
  int cyc = 0, rise_cyc = 0, hi_len = 0, mst = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if ((mst == 1 || mst == 2) && (cyc - rise_cyc == TMO + 1)) begin
      exp_q.push_back(exp_t'{16'hFFFF, (pwm_in ? 16'hFFFF : 16'h0000), 1'b1});
      mst = 3;
    end
  endtask

  task automatic drive_level(input logic lvl, input int n);
    if (lvl && !pwm_in) begin
      if (mst == 2) exp_q.push_back(exp_t'{16'(cyc - rise_cyc), 16'(hi_len), 1'b0});
      mst      = 1;
      rise_cyc = cyc;
    end else if (!lvl && pwm_in && mst == 1) begin
      hi_len = cyc - rise_cyc;
      mst    = 2;
    end
    pwm_in = lvl;
    repeat (n) tick();
  endtask

  task automatic pwm(input int per, input int hi, input int n);
    for (int i = 0; i < n; i++) begin
      drive_level(1'b1, hi);
      drive_level(1'b0, per - hi);
    end
  endtask

  task automatic glitch();
    pwm_in = ~pwm_in;
    tick();
    pwm_in = ~pwm_in;
  endtask

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_period", {16'd0, period}, {16'd0, mon_e.per});
        chk("sb_duty", {16'd0, duty_cycle}, {16'd0, mon_e.duty});
        chk("sb_timeout", {31'd0, timeout}, {31'd0, mon_e.to});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    pwm_in = 1'b0;
    pwm2   = 1'b0;
    repeat (3) tick();
    chk("rst_period", {16'd0, period}, 32'd0);
    chk("rst_duty", {16'd0, duty_cycle}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    reset = 1'b0;
    tick();

    // Latency with FILTER=3: rise captured at edge k -> valid registered at k+4
    pwm2 = 1'b1;
    repeat (10) tick();
    pwm2 = 1'b0;
    repeat (20) tick();
    pwm2 = 1'b1;
    repeat (4) tick();
    chk("lat_early", {31'd0, valid2}, 32'd0);
    tick();
    chk("lat_valid", {31'd0, valid2}, 32'd1);
    chk("lat_period", {16'd0, period2}, 32'd30);
    chk("lat_duty", {16'd0, duty2}, 32'd10);
    tick();
    chk("lat_pulse_len", {31'd0, valid2}, 32'd0);

    // Steady PWM
    pwm(1000, 250, 4);

    // Glitches in both phases must leave the measurement untouched
    drive_level(1'b1, 100);
    glitch();
    drive_level(1'b1, 149);
    drive_level(1'b0, 300);
    glitch();
    drive_level(1'b0, 449);
    chk("glitch_period", {16'd0, period}, 32'd1000);
    chk("glitch_duty", {16'd0, duty_cycle}, 32'd250);
    chk("glitch_timeout", {31'd0, timeout}, 32'd0);
    pwm(1000, 250, 1);

    // Period change
    pwm(1000, 500, 2);
    pwm(400, 100, 3);

    // Stall high
    drive_level(1'b1, 5003);
    chk("stall_hi_pre", {31'd0, timeout}, 32'd0);
    tick();
    chk("stall_hi_to", {31'd0, timeout}, 32'd1);
    chk("stall_hi_valid", {31'd0, valid}, 32'd1);
    chk("stall_hi_period", {16'd0, period}, 32'hFFFF);
    chk("stall_hi_duty", {16'd0, duty_cycle}, 32'hFFFF);
    drive_level(1'b1, 200);
    drive_level(1'b0, 100);
    drive_level(1'b1, 3);
    chk("to_hold", {31'd0, timeout}, 32'd1);
    tick();
    chk("to_clear", {31'd0, timeout}, 32'd0);
    drive_level(1'b1, 196);
    drive_level(1'b0, 600);
    pwm(800, 200, 2);

    // Stall low
    drive_level(1'b1, 200);
    drive_level(1'b0, 5000);
    chk("stall_lo_to", {31'd0, timeout}, 32'd1);
    chk("stall_lo_period", {16'd0, period}, 32'hFFFF);
    chk("stall_lo_duty", {16'd0, duty_cycle}, 32'd0);
    pwm(500, 100, 3);

    // Reset in the middle of a high phase
    drive_level(1'b1, 50);
    reset = 1'b1;
    tick();
    chk("mid_rst_period", {16'd0, period}, 32'd0);
    chk("mid_rst_duty", {16'd0, duty_cycle}, 32'd0);
    chk("mid_rst_valid", {31'd0, valid}, 32'd0);
    chk("mid_rst_timeout", {31'd0, timeout}, 32'd0);
    reset = 1'b0;
    mst   = 0;
    drive_level(1'b0, 100);
    pwm(600, 150, 3);

    repeat (20) tick();
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
